// File: rtl/lcd_ctrl_if.sv
// CPU-side register word in, HD44780 bus and status flags out.
// The controller takes the slave view; the CPU or a bench takes the master view.
interface lcd_ctrl_if;
   logic [31:0] i_lcd_word;
   logic [7:0]  o_lcd_data;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic        o_lcd_en;
   logic        o_lcd_on;
   logic        o_busy;
   logic        o_ovf;

   modport slave (
      input  i_lcd_word,
      output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_ovf
   );

   modport master (
      output i_lcd_word,
      input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_ovf
   );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up delay, fixed init sequence, then
// toggle-requested commands from a 4-deep FIFO, all timed by one down-counter.
module lcd_ctrl #(
   parameter int unsigned T_SETUP_CYC = 2,
   parameter int unsigned T_EN_CYC    = 12,
   parameter int unsigned T_HOLD_CYC  = 2,
   parameter int unsigned T_SHORT_CYC = 2000,
   parameter int unsigned T_LONG_CYC  = 80000,
   parameter int unsigned T_PWRUP_CYC = 750000
) (
   input  logic        i_clk,
   input  logic        rst,
   lcd_ctrl_if.slave   bus
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_SHORT_CYC)),
                                        max2(T_LONG_CYC, T_PWRUP_CYC));
   localparam int CW = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

   localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP_CYC);
   localparam logic [CW-1:0] C_EN    = CW'(T_EN_CYC);
   localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD_CYC);
   localparam logic [CW-1:0] C_SHORT = CW'(T_SHORT_CYC);
   localparam logic [CW-1:0] C_LONG  = CW'(T_LONG_CYC);
   localparam logic [CW-1:0] C_PWRUP = CW'(T_PWRUP_CYC);

   localparam logic [2:0] S_PWRUP = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_IDLE  = 3'd2;
   localparam logic [2:0] S_SETUP = 3'd3;
   localparam logic [2:0] S_EN_HI = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;
   localparam logic [2:0] S_WAIT  = 3'd6;

   typedef struct packed {
      logic       rs;
      logic [7:0] dat;
   } cmd_t;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          done;
   logic          en_q, rs_q, on_q, ovf_q;
   logic [7:0]    data_q;
   logic [1:0]    init_idx;
   logic          init_done;
   logic          long_cmd;

   logic          tog_q, req;
   cmd_t          cmd_in, cmd_head;
   cmd_t          fifo_mem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    fifo_cnt;
   logic          fifo_empty, fifo_full, push, pop, drop;

   logic          unused_bits;
   assign unused_bits = ^{bus.i_lcd_word[30:11], bus.i_lcd_word[8]};

   // A count of N means N cycles in the state: leave on the cycle that sees 1.
   assign done = (cnt <= CW'(1));

   assign req      = bus.i_lcd_word[10] ^ tog_q;
   assign cmd_in   = '{rs: bus.i_lcd_word[9], dat: bus.i_lcd_word[7:0]};
   assign cmd_head = fifo_mem[rd_ptr];

   assign fifo_empty = (fifo_cnt == 3'd0);
   assign fifo_full  = (fifo_cnt == 3'd4);
   assign pop        = (state == S_IDLE) && !fifo_empty;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
   assign push       = req && (!fifo_full || pop);
   assign drop       = req && fifo_full && !pop;

   assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

   // Tracking the toggle bit in reset too means a level held across release is not a request.
   always_ff @(posedge i_clk) begin
      tog_q <= bus.i_lcd_word[10];
      if (!rst) on_q <= 1'b0;
      else      on_q <= bus.i_lcd_word[31];
   end

   always_ff @(posedge i_clk) begin
      if (!rst) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (drop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!rst) begin
         state     <= S_PWRUP;
         cnt       <= C_PWRUP;
         en_q      <= 1'b0;
         data_q    <= 8'h00;
         rs_q      <= 1'b0;
         init_idx  <= 2'd0;
         init_done <= 1'b0;
      end else begin
         if (!done) cnt <= cnt - CW'(1);
         case (state)
            S_PWRUP: if (done) state <= S_INIT;
            S_INIT: begin
               data_q <= init_byte(init_idx);
               rs_q   <= 1'b0;
               cnt    <= C_SETUP;
               state  <= S_SETUP;
            end
            S_IDLE: if (pop) begin
               data_q <= cmd_head.dat;
               rs_q   <= cmd_head.rs;
               cnt    <= C_SETUP;
               state  <= S_SETUP;
            end
            S_SETUP: if (done) begin
               en_q  <= 1'b1;
               cnt   <= C_EN;
               state <= S_EN_HI;
            end
            S_EN_HI: if (done) begin
               en_q  <= 1'b0;
               cnt   <= C_HOLD;
               state <= S_HOLD;
            end
            S_HOLD: if (done) begin
               cnt   <= long_cmd ? C_LONG : C_SHORT;
               state <= S_WAIT;
            end
            S_WAIT: if (done) begin
               if (init_done) begin
                  state <= S_IDLE;
               end else if (init_idx == 2'd3) begin
                  init_done <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  init_idx <= init_idx + 2'd1;
                  state    <= S_INIT;
               end
            end
            default: state <= S_PWRUP;
         endcase
      end
   end

   assign bus.o_lcd_data = data_q;
   assign bus.o_lcd_rs   = rs_q;
   assign bus.o_lcd_rw   = 1'b0;
   assign bus.o_lcd_en   = en_q;
   assign bus.o_lcd_on   = on_q;
   assign bus.o_ovf      = ovf_q;
   assign bus.o_busy     = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; a negedge monitor logs
// every EN pulse (data, RS, width, setup stability, preceding gap).
module tb_lcd_ctrl;
   localparam int P_SETUP = 2;
   localparam int P_EN    = 3;
   localparam int P_HOLD  = 2;
   localparam int P_SHORT = 10;
   localparam int P_LONG  = 40;
   localparam int P_PWR   = 20;
   localparam int NP      = 256;

   logic        i_clk = 1'b0;
   logic        rst;
   logic [31:0] w;

   lcd_ctrl_if bus ();
   assign bus.i_lcd_word = w;

   lcd_ctrl #(
      .T_SETUP_CYC(P_SETUP), .T_EN_CYC(P_EN), .T_HOLD_CYC(P_HOLD),
      .T_SHORT_CYC(P_SHORT), .T_LONG_CYC(P_LONG), .T_PWRUP_CYC(P_PWR)
   ) dut (
      .i_clk(i_clk),
      .rst  (rst),
      .bus  (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   int vectors = 0;
   int errs    = 0;

   int       cyc = 0;
   int       n_pulse = 0;
   int       mon_err = 0;
   logic [7:0] p_data [NP];
   logic       p_rs   [NP];
   int       p_width [NP];
   int       p_setup [NP];
   int       p_gap   [NP];
   int       p_rise  [NP];

   logic [8:0] last_bus = '0, pulse_bus = '0, cur;
   logic       prev_en = 1'b0;
   int         stable = 0, width = 0, gap = 0, hold_left = 0;
   int         setup_t = 0, gap_t = 0, rise_t = 0;

   always @(negedge i_clk) begin
      cyc = cyc + 1;
      cur = {bus.o_lcd_rs, bus.o_lcd_data};
      stable = (cur == last_bus) ? stable + 1 : 0;
      last_bus = cur;
      if (bus.o_lcd_en) begin
         if (!prev_en) begin
            pulse_bus = cur; width = 0; setup_t = stable; gap_t = gap; rise_t = cyc;
         end
         width = width + 1;
         if (rst && cur != pulse_bus) mon_err = mon_err + 1;
      end else if (prev_en) begin
         if (n_pulse < NP) begin
            p_data[n_pulse] = pulse_bus[7:0]; p_rs[n_pulse] = pulse_bus[8];
            p_width[n_pulse] = width; p_setup[n_pulse] = setup_t;
            p_gap[n_pulse] = gap_t; p_rise[n_pulse] = rise_t;
         end
         n_pulse = n_pulse + 1;
         if (rst && cur != pulse_bus) mon_err = mon_err + 1;
         hold_left = P_HOLD - 1;
         gap = 1;
      end else begin
         gap = gap + 1;
         if (hold_left > 0) begin
            if (rst && cur != pulse_bus) mon_err = mon_err + 1;
            hold_left = hold_left - 1;
         end
      end
      if (!rst) hold_left = 0;
      prev_en = bus.o_lcd_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic rs_b, input logic [7:0] b);
      w[10]  = ~w[10];
      w[9]   = rs_b;
      w[7:0] = b;
      @(negedge i_clk);
   endtask

   task automatic wait_idle(input int bound, input string tag);
      for (int i = 0; i < bound && bus.o_busy !== 1'b0; i++) @(negedge i_clk);
      chk(tag, {31'd0, bus.o_busy}, 32'd0);
   endtask

   task automatic wait_en(input logic v, input int bound, input string tag);
      for (int i = 0; i < bound && bus.o_lcd_en !== v; i++) @(negedge i_clk);
      chk(tag, {31'd0, bus.o_lcd_en}, {31'd0, v});
   endtask

   function automatic logic [7:0] pd(input int i);
      return (i >= 0 && i < NP) ? p_data[i] : 8'hxx;
   endfunction

   logic [7:0] init_exp [4];
   logic [7:0] burst_exp [5];
   int base, rel;

   initial begin
      init_exp  = '{8'h38, 8'h0C, 8'h01, 8'h06};
      burst_exp = '{8'h20, 8'h30, 8'h31, 8'h32, 8'h33};

      // reset values, with the power bit already requested
      rst = 1'b0;
      w   = 32'h8000_0000;
      repeat (3) @(negedge i_clk);
      chk("rst_en",   {31'd0, bus.o_lcd_en}, 32'd0);
      chk("rst_data", {24'd0, bus.o_lcd_data}, 32'd0);
      chk("rst_rs",   {31'd0, bus.o_lcd_rs}, 32'd0);
      chk("rst_on",   {31'd0, bus.o_lcd_on}, 32'd0);
      chk("rst_busy", {31'd0, bus.o_busy}, 32'd1);
      chk("rst_ovf",  {31'd0, bus.o_ovf}, 32'd0);
      chk("rw_zero",  {31'd0, bus.o_lcd_rw}, 32'd0);

      // power-up and init
      base = n_pulse;
      rst  = 1'b1;
      rel  = cyc;
      @(negedge i_clk);
      chk("on_follow", {31'd0, bus.o_lcd_on}, 32'd1);
      chk("pwrup_busy", {31'd0, bus.o_busy}, 32'd1);
      wait_idle(400, "init_idle");
      repeat (3) @(negedge i_clk);
      chk("init_count", n_pulse - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init_data%0d", i), {24'd0, pd(base + i)}, {24'd0, init_exp[i]});
         chk($sformatf("init_rs%0d", i), {31'd0, p_rs[base + i]}, 32'd0);
         chk($sformatf("init_width%0d", i), p_width[base + i], P_EN);
      end
      chk("pwrup_delay", {31'd0, (p_rise[base] - rel >= P_PWR) && (p_rise[base] - rel <= P_PWR + 6)}, 32'd1);
      chk("long_gap",  {31'd0, p_gap[base + 3] >= P_LONG}, 32'd1);
      chk("short_gap", {31'd0, p_gap[base + 1] <  P_LONG}, 32'd1);
      chk("init_ovf",  {31'd0, bus.o_ovf}, 32'd0);

      // single data write
      base = n_pulse;
      send(1'b1, 8'h41);
      wait_idle(200, "wr41_idle");
      repeat (3) @(negedge i_clk);
      chk("wr41_count", n_pulse - base, 1);
      chk("wr41_data",  {24'd0, pd(base)}, 32'h41);
      chk("wr41_rs",    {31'd0, p_rs[base]}, 32'd1);
      chk("wr41_width", p_width[base], P_EN);
      chk("wr41_setup", {31'd0, p_setup[base] >= P_SETUP}, 32'd1);
      chk("wr41_hold",  mon_err, 0);

      // six requests during a WAIT: four queue, two drop
      base = n_pulse;
      send(1'b1, 8'h20);
      wait_en(1'b1, 50, "ovf_en_hi");
      wait_en(1'b0, 50, "ovf_en_lo");
      repeat (P_HOLD) @(negedge i_clk);
      for (int k = 0; k < 6; k++) send(1'b1, 8'h30 + 8'(k));
      chk("ovf_set", {31'd0, bus.o_ovf}, 32'd1);
      wait_idle(500, "ovf_idle");
      repeat (3) @(negedge i_clk);
      chk("ovf_count", n_pulse - base, 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("ovf_data%0d", k), {24'd0, pd(base + k)}, {24'd0, burst_exp[k]});
      chk("ovf_sticky", {31'd0, bus.o_ovf}, 32'd1);
      chk("ovf_stable", mon_err, 0);

      // toggle bit held high across reset release
      rst   = 1'b0;
      w[10] = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst2_ovf", {31'd0, bus.o_ovf}, 32'd0);
      base = n_pulse;
      rst  = 1'b1;
      wait_idle(400, "hold_idle");
      repeat (60) @(negedge i_clk);
      chk("hold_count", n_pulse - base, 4);
      chk("hold_last",  {24'd0, pd(base + 3)}, 32'h06);
      chk("hold_busy",  {31'd0, bus.o_busy}, 32'd0);

      // reset during EN high with more requests queued
      send(1'b1, 8'h55);
      wait_en(1'b1, 50, "abort_en_hi");
      send(1'b1, 8'h56);
      w[10] = ~w[10]; w[7:0] = 8'h57;
      rst = 1'b0;
      @(negedge i_clk);
      chk("abort_en",   {31'd0, bus.o_lcd_en}, 32'd0);
      chk("abort_data", {24'd0, bus.o_lcd_data}, 32'd0);
      chk("abort_busy", {31'd0, bus.o_busy}, 32'd1);
      repeat (2) @(negedge i_clk);
      base = n_pulse;
      rst  = 1'b1;
      wait_idle(400, "abort_idle");
      repeat (60) @(negedge i_clk);
      chk("abort_count", n_pulse - base, 4);
      chk("abort_first", {24'd0, pd(base)}, 32'h38);
      chk("abort_last",  {24'd0, pd(base + 3)}, 32'h06);
      chk("abort_stable", mon_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
  - T_SETUP_CYC, 2: RS/RW/DATA setup cycles before EN rises.
  - T_EN_CYC, 12: EN high-pulse width in cycles.
  - T_HOLD_CYC, 2: cycles after EN falls before the bus may change.
  - T_SHORT_CYC, 2000: post-command wait for ordinary commands and data.
  - T_LONG_CYC, 80000: post-command wait for clear/home.
  - T_PWRUP_CYC, 750000: wait after reset before init.
REQ-002 Ports (name, direction, width, meaning):
  - i_clk, in, 1: clock.
  - rst, in, 1: reset, synchronous, active-low.
  - i_lcd_word, in, 32: LCD register from CPU. [31] display power; [10] request toggle; [9] RS; [7:0] byte.
  - o_lcd_data, out, 8: HD44780 DB7..DB0.
  - o_lcd_rs, out, 1: register select.
  - o_lcd_rw, out, 1: read/write; tied to 0 (write only).
  - o_lcd_en, out, 1: enable strobe.
  - o_lcd_on, out, 1: panel power/backlight.
  - o_busy, out, 1: high while power-up/init runs, FIFO non-empty, or a write/wait is in progress.
  - o_ovf, out, 1: sticky overflow flag.
REQ-003 Reset is rst, synchronous, active-low; clock is i_clk; all state updates on the rising edge of i_clk.

Function
REQ-004 A request is a change of i_lcd_word[10] versus its value on the previous cycle; one change is one request.
REQ-005 On each request, push {RS=i_lcd_word[9], byte=i_lcd_word[7:0]} from the same cycle into a 4-entry FIFO.
REQ-006 If the FIFO is full when a request occurs, drop the request and set o_ovf; o_ovf clears only on reset.
REQ-007 A push and a pop in the same cycle are both honoured, with no drop when the FIFO is full at that cycle.
REQ-008 o_lcd_on = registered i_lcd_word[31], updated every cycle and independent of the FSM.
REQ-009 FSM states: PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-010 PWRUP: count T_PWRUP_CYC cycles, then go to INIT.
REQ-011 INIT issues four commands with RS=0 through SETUP..WAIT: 0x38, 0x0C, 0x01, 0x06; after the last WAIT, go to IDLE.
REQ-012 IDLE: when the FIFO is non-empty, pop the head, latch it onto o_lcd_data/o_lcd_rs, and go to SETUP.
REQ-013 SETUP lasts T_SETUP_CYC cycles with EN=0.
REQ-014 EN_HI lasts T_EN_CYC cycles with EN=1.
REQ-015 HOLD lasts T_HOLD_CYC cycles with EN=0.
REQ-016 WAIT lasts T_LONG_CYC if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise it lasts T_SHORT_CYC.
REQ-017 Leaving WAIT: return to INIT if init is not finished, else to IDLE.
REQ-018 o_lcd_data and o_lcd_rs are stable from SETUP entry through HOLD exit; they change only when a new command is latched.
REQ-019 Requests arriving during PWRUP/INIT are queued and run after init, in arrival order.
REQ-020 A single shared down-counter times all states; it is wide enough for the largest parameter; a count of N gives exactly N cycles in the state.
REQ-021 o_lcd_en is registered (glitch-free); o_lcd_rw is constant 0.

Reset
REQ-022 While rst=0 the following hold:
  - state=PWRUP and counter loaded with T_PWRUP_CYC.
  - FIFO emptied, o_ovf=0, o_busy=1.
  - o_lcd_en=0, o_lcd_data=0x00, o_lcd_rs=0, o_lcd_on=0.
  - init index=0.
  - The previous-toggle register is loaded with i_lcd_word[10], so no request is detected on the first cycle after release.
REQ-023 Reset asserted mid-operation aborts any pulse or wait at once: EN=0 on the next edge, and queued commands are lost.

Verification (small timing parameters allowed, e.g. PWRUP=20, SHORT=10, LONG=40)
REQ-024 Release reset with no requests. Required response:
  - EN pulses exactly 4 times with data 0x38, 0x0C, 0x01, 0x06, each with RS=0.
  - The gap after 0x01 is at least T_LONG_CYC.
  - o_busy falls after the last wait.
REQ-025 After init, toggle bit10 with RS=1 and byte 0x41. Required response:
  - One EN pulse exactly T_EN_CYC wide, data=0x41, RS=1.
  - Data is stable T_SETUP_CYC cycles before and T_HOLD_CYC cycles after the pulse.
REQ-026 During a WAIT, toggle bit10 six times with bytes 0x30..0x35. Required response:
  - Bytes 0x30..0x33 are emitted in order; 0x34 and 0x35 are dropped.
  - o_ovf=1 and stays set.
REQ-027 Hold bit10 steady at 1 across reset release. Required response: no write occurs after init.
REQ-028 Assert rst during EN_HI. Required response:
  - EN=0 on the next edge; FIFO is empty.
  - After release the full power-up and init sequence repeats.
